codec_slave_intf: RTL and testbench

Codec-side responder for the serial audio link driven by the digital core's codec master interface. Receives the master-generated LRCLK/SCLK and the SDin stream, and deserialises left/right samples. Serialises its own left/right samples onto SDout in the slot positions the master captures. Used as a synthesizable codec stand-in for loopback/FPGA bring-up and as the bench responder.

---
 rtl/codec_slave_intf.sv | 199 +++++++++++++++++++
 tb/tb_codec_slave_intf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_slave_intf.sv
// Codec-side responder for the serial audio link: resynchronises the master's LRCLK/SCLK/SDin,
// deserialises left-justified samples and serialises right-justified samples onto SDout.
module codec_slave_intf #(
    parameter int DATA_W = 16,
    parameter int SLOTS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LRCLK,
    input  logic              SCLK,
    input  logic              SDin,
    output logic              SDout,
    input  logic [DATA_W-1:0] tx_lft,
    input  logic [DATA_W-1:0] tx_rht,
    output logic [DATA_W-1:0] rx_lft,
    output logic [DATA_W-1:0] rx_rht,
    output logic              rx_valid,
    output logic              tx_req
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
    localparam logic [CW-1:0] DW_C    = CW'(DATA_W);
    localparam logic [CW-1:0] DWM1_C  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] START_C = CW'(SLOTS - DATA_W);

    // Pin synchronisers and edge history
    logic lrclk_s1_q, lrclk_s1_d, lrclk_s2_q, lrclk_s2_d, lrclk_h_q, lrclk_h_d;
    logic sclk_s1_q,  sclk_s1_d,  sclk_s2_q,  sclk_s2_d,  sclk_h_q,  sclk_h_d;
    logic sdin_s1_q,  sdin_s1_d,  sdin_s2_q,  sdin_s2_d;

    logic              locked_q,    locked_d;
    logic [CW-1:0]     rcnt_q,      rcnt_d;
    logic [DATA_W-1:0] rx_shift_q,  rx_shift_d;
    logic [DATA_W-1:0] lft_stage_q, lft_stage_d;
    logic [DATA_W-1:0] rht_stage_q, rht_stage_d;
    logic              lft_ok_q,    lft_ok_d;
    logic              rht_ok_q,    rht_ok_d;
    logic [DATA_W-1:0] rx_lft_q,    rx_lft_d;
    logic [DATA_W-1:0] rx_rht_q,    rx_rht_d;
    logic              rx_valid_q,  rx_valid_d;
    logic [DATA_W-1:0] tx_hold_l_q, tx_hold_l_d;
    logic [DATA_W-1:0] tx_hold_r_q, tx_hold_r_d;
    logic              sdout_q,     sdout_d;

    logic              lr_rise, lr_fall, lr_edge;
    logic              sclk_rise, sclk_fall;
    logic [CW-1:0]     rise_idx;
    logic [DATA_W-1:0] shift_in;

    assign lr_rise   =  lrclk_s2_q & ~lrclk_h_q;
    assign lr_fall   = ~lrclk_s2_q &  lrclk_h_q;
    assign lr_edge   =  lr_rise | lr_fall;
    assign sclk_rise =  sclk_s2_q & ~sclk_h_q;
    assign sclk_fall = ~sclk_s2_q &  sclk_h_q;

    assign SDout    = sdout_q;
    assign rx_lft   = rx_lft_q;
    assign rx_rht   = rx_rht_q;
    assign rx_valid = rx_valid_q;
    // tx_lft/tx_rht are captured at the clock edge closing this strobe cycle
    assign tx_req   = lr_rise & ~rst;

    // Right-justified slot mapping: rise k carries word[SLOTS-1-k] in the last DATA_W slots
    function automatic logic tx_bit(input logic [CW-1:0] k, input logic [DATA_W-1:0] word);
        logic [IW-1:0] idx;
        idx = IW'(SLOTS_C - k - CW'(1));
        if (k >= START_C && k < SLOTS_C) begin
            return word[idx];
        end
        return 1'b0;
    endfunction

    always_comb begin
        lrclk_s1_d  = LRCLK;
        lrclk_s2_d  = lrclk_s1_q;
        lrclk_h_d   = lrclk_s2_q;
        sclk_s1_d   = SCLK;
        sclk_s2_d   = sclk_s1_q;
        sclk_h_d    = sclk_s2_q;
        sdin_s1_d   = SDin;
        sdin_s2_d   = sdin_s1_q;

        locked_d    = locked_q;
        rcnt_d      = rcnt_q;
        rx_shift_d  = rx_shift_q;
        lft_stage_d = lft_stage_q;
        rht_stage_d = rht_stage_q;
        lft_ok_d    = lft_ok_q;
        rht_ok_d    = 1'b0;
        rx_lft_d    = rx_lft_q;
        rx_rht_d    = rx_rht_q;
        rx_valid_d  = 1'b0;
        tx_hold_l_d = tx_hold_l_q;
        tx_hold_r_d = tx_hold_r_q;
        sdout_d     = sdout_q;

        rise_idx = lr_edge ? CW'(0) : rcnt_q;
        shift_in = {rx_shift_q[DATA_W-2:0], sdin_s2_q};

        // The pair is published the cycle after the right word lands
        if (rht_ok_q && lft_ok_q) begin
            rx_lft_d   = lft_stage_q;
            rx_rht_d   = rht_stage_q;
            rx_valid_d = 1'b1;
            lft_ok_d   = 1'b0;
        end

        if (locked_q || lr_rise) begin
            locked_d = 1'b1;

            if (lr_edge) begin
                rcnt_d = CW'(0);
                // A left half cut short never pairs with the following right half
                if (lr_fall && rcnt_q < DW_C) begin
                    lft_ok_d = 1'b0;
                end
                if (lr_rise) begin
                    tx_hold_l_d = tx_lft;
                    tx_hold_r_d = tx_rht;
                    sdout_d     = tx_bit(CW'(0), tx_lft);
                end else begin
                    sdout_d     = tx_bit(CW'(0), tx_hold_r_q);
                end
            end else if (sclk_fall) begin
                sdout_d = tx_bit(rcnt_q, lrclk_s2_q ? tx_hold_l_q : tx_hold_r_q);
            end

            if (sclk_rise) begin
                if (rise_idx < SLOTS_C) begin
                    rcnt_d = rise_idx + CW'(1);
                end
                if (rise_idx < DW_C) begin
                    rx_shift_d = shift_in;
                    if (rise_idx == DWM1_C) begin
                        if (lrclk_s2_q) begin
                            lft_stage_d = shift_in;
                            lft_ok_d    = 1'b1;
                        end else begin
                            rht_stage_d = shift_in;
                            rht_ok_d    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lrclk_s1_q  <= 1'b0;
            lrclk_s2_q  <= 1'b0;
            lrclk_h_q   <= 1'b0;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_h_q    <= 1'b0;
            sdin_s1_q   <= 1'b0;
            sdin_s2_q   <= 1'b0;
            locked_q    <= 1'b0;
            rcnt_q      <= '0;
            rx_shift_q  <= '0;
            lft_stage_q <= '0;
            rht_stage_q <= '0;
            lft_ok_q    <= 1'b0;
            rht_ok_q    <= 1'b0;
            rx_lft_q    <= '0;
            rx_rht_q    <= '0;
            rx_valid_q  <= 1'b0;
            tx_hold_l_q <= '0;
            tx_hold_r_q <= '0;
            sdout_q     <= 1'b0;
        end else begin
            lrclk_s1_q  <= lrclk_s1_d;
            lrclk_s2_q  <= lrclk_s2_d;
            lrclk_h_q   <= lrclk_h_d;
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_h_q    <= sclk_h_d;
            sdin_s1_q   <= sdin_s1_d;
            sdin_s2_q   <= sdin_s2_d;
            locked_q    <= locked_d;
            rcnt_q      <= rcnt_d;
            rx_shift_q  <= rx_shift_d;
            lft_stage_q <= lft_stage_d;
            rht_stage_q <= rht_stage_d;
            lft_ok_q    <= lft_ok_d;
            rht_ok_q    <= rht_ok_d;
            rx_lft_q    <= rx_lft_d;
            rx_rht_q    <= rx_rht_d;
            rx_valid_q  <= rx_valid_d;
            tx_hold_l_q <= tx_hold_l_d;
            tx_hold_r_q <= tx_hold_r_d;
            sdout_q     <= sdout_d;
        end
    end

endmodule

// File: tb/tb_codec_slave_intf.sv
// Bench for codec_slave_intf: a behavioural link master (SCLK = clk/32, 32 slots per half)
// drives frames and scores received pairs and master-captured SDout words.
module tb_codec_slave_intf;

    localparam int DW   = 16;
    localparam int SL   = 32;
    localparam int HALF = 16;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        lrclk  = 1'b0;
    logic        sclk   = 1'b1;
    logic        sdin   = 1'b0;
    logic [15:0] tx_lft = 16'h0;
    logic [15:0] tx_rht = 16'h0;
    logic        sdout;
    logic [15:0] rx_lft;
    logic [15:0] rx_rht;
    logic        rx_valid;
    logic        tx_req;

    always #5 clk = ~clk;

    codec_slave_intf #(.DATA_W(DW), .SLOTS(SL)) dut (
        .clk      (clk),
        .rst      (rst),
        .LRCLK    (lrclk),
        .SCLK     (sclk),
        .SDin     (sdin),
        .SDout    (sdout),
        .tx_lft   (tx_lft),
        .tx_rht   (tx_rht),
        .rx_lft   (rx_lft),
        .rx_rht   (rx_rht),
        .rx_valid (rx_valid),
        .tx_req   (tx_req)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected {left, right} pairs, oldest first
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    // Reference model state
    logic        locked_m  = 1'b0;
    logic        pend_l    = 1'b0;
    logic [15:0] pend_w    = 16'h0;
    logic [15:0] last_l    = 16'h0;
    logic [15:0] last_r    = 16'h0;
    logic [15:0] exp_tx_l  = 16'h0;
    logic [15:0] exp_tx_r  = 16'h0;
    logic        upd_pend  = 1'b0;
    logic [15:0] upd_val   = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                check("rx_valid_unexpected", 32'(rx_valid), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_pair", {rx_lft, rx_rht}, mon_e);
            end
        end
    end

    // One LRCLK half: nrise SCLK periods, optional reset pulse after rise rst_at
    task automatic run_half(input logic lvl, input logic [15:0] word, input int nrise, input int rst_at);
        logic [15:0] cap;
        logic        nz;
        logic        b;
        cap = 16'h0;
        nz  = 1'b0;
        for (int s = 0; s < nrise; s++) begin
            @(negedge clk);
            sclk = 1'b0;
            if (s == 0) begin
                lrclk = lvl;
                if (lvl) begin
                    locked_m = 1'b1;
                    pend_l   = 1'b0;
                end
            end
            sdin = (s < DW) ? word[DW-1-s] : 1'b0;
            for (int i = 1; i < HALF; i++) begin
                @(negedge clk);
                if (s == 0 && lvl && i <= 3) begin
                    check("tx_req_timing", 32'(tx_req), 32'(i == 2));
                    if (i == 2) begin
                        exp_tx_l = tx_lft;
                        exp_tx_r = tx_rht;
                    end
                    if (i == 3 && upd_pend) begin
                        tx_lft   = upd_val;
                        upd_pend = 1'b0;
                    end
                end
            end
            @(negedge clk);
            sclk = 1'b1;
            b = sdout;
            if (!locked_m || s < SL - DW) nz = nz | b;
            else cap = {cap[14:0], b};
            if (s == DW - 1 && locked_m) begin
                if (lvl) begin
                    pend_l = 1'b1;
                    pend_w = word;
                end else if (pend_l) begin
                    exp_q.push_back({pend_w, word});
                    last_l = pend_w;
                    last_r = word;
                    pend_l = 1'b0;
                end
            end
            for (int i = 1; i < HALF; i++) begin
                @(negedge clk);
                if (s == rst_at) begin
                    if (i == 1) rst = 1'b1;
                    if (i == 2) begin
                        check("midrst_sdout", 32'(sdout), 32'(0));
                        check("midrst_rx", {rx_lft, rx_rht}, 32'(0));
                        check("midrst_strobes", {30'(0), rx_valid, tx_req}, 32'(0));
                    end
                    if (i == 3) begin
                        rst      = 1'b0;
                        locked_m = 1'b0;
                        pend_l   = 1'b0;
                        last_l   = 16'h0;
                        last_r   = 16'h0;
                        exp_q.delete();
                    end
                end
            end
        end
        check("sdout_zero_slots", 32'(nz), 32'(0));
        if (locked_m && nrise == SL) begin
            if (lvl) check("tx_left_word", 32'(cap), 32'(exp_tx_l));
            else     check("tx_right_word", 32'(cap), 32'(exp_tx_r));
        end
        if (!lvl) begin
            check("rx_hold", {rx_lft, rx_rht}, {last_l, last_r});
            check("rx_delivered", 32'(exp_q.size()), 32'(0));
        end
    endtask

    task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                             input int rst_at, input logic set_tx, input logic [15:0] tl,
                             input logic [15:0] tr, input logic upd, input logic [15:0] uv,
                             input logic chg_mid);
        if (set_tx) begin
            tx_lft = tl;
            tx_rht = tr;
        end
        upd_pend = upd;
        upd_val  = uv;
        run_half(1'b1, l, nl, -1);
        if (chg_mid) begin
            tx_lft = 16'($urandom);
            tx_rht = 16'($urandom);
        end
        run_half(1'b0, r, SL, rst_at);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            lrclk = 1'($urandom);
            sclk  = 1'($urandom);
            sdin  = 1'($urandom);
            check("reset_sdout", 32'(sdout), 32'(0));
            check("reset_rx", {rx_lft, rx_rht}, 32'(0));
            check("reset_strobes", {30'(0), rx_valid, tx_req}, 32'(0));
        end
        @(negedge clk);
        rst   = 1'b0;
        lrclk = 1'b0;
        sclk  = 1'b1;
        sdin  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("prelock_idle", {29'(0), sdout, rx_valid, tx_req}, 32'(0));
        end

        // Unlocked half: no activity expected
        run_half(1'b0, 16'($urandom), SL, -1);

        // Fixed loopback and tx patterns
        run_frame(16'h8001, 16'h7FFE, SL, -1, 1'b1, 16'hA5C3, 16'h1234, 1'b0, 16'h0, 1'b0);
        run_frame(16'h8001, 16'h7FFE, SL, -1, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, 1'b0);

        // tx_lft changes one cycle after tx_req: effective from the next frame
        run_frame(16'($urandom), 16'($urandom), SL, -1, 1'b1, 16'h0001, 16'($urandom), 1'b1, 16'hFFFF, 1'b0);
        run_frame(16'($urandom), 16'($urandom), SL, -1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);

        // Short left half, then a full frame
        run_frame(16'($urandom), 16'($urandom), 10, -1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        run_frame(16'($urandom), 16'($urandom), SL, -1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);

        // Reset during the right half, then relock
        run_frame(16'($urandom), 16'($urandom), SL, 8, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 16'h0, 1'b0);

        for (int f = 0; f < 5; f++) begin
            run_frame(16'($urandom), 16'($urandom), SL, -1, 1'($urandom), 16'($urandom),
                      16'($urandom), 1'b0, 16'h0, 1'($urandom));
        end

        repeat (20) @(negedge clk);
        check("rx_delivered_end", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
